// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display driver: nibble/segment widths
// and the segment patterns (bit0=a .. bit6=g) for every displayable glyph.
package seven_segment_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-segment decoder; 10..15 show A b C d E F only in hex mode.
module seg_decoder
    import seven_segment_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             hex_mode_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = hex_mode_i ? SEG_A : SEG_BLANK;
            4'hB: seg_c = hex_mode_i ? SEG_B : SEG_BLANK;
            4'hC: seg_c = hex_mode_i ? SEG_C : SEG_BLANK;
            4'hD: seg_c = hex_mode_i ? SEG_D : SEG_BLANK;
            4'hE: seg_c = hex_mode_i ? SEG_E : SEG_BLANK;
            4'hF: seg_c = hex_mode_i ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned double
// buffering, leading-zero blanking, PWM brightness and selectable polarity.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [NIB_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          hex_mode,
    input  logic                          blank_lz,
    input  logic [$clog2(SCAN_DIV+1)-1:0] brightness,
    output logic [SEG_W-1:0]              segments,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_start
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BRT_W = $clog2(SCAN_DIV + 1);

    typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] nib_arr_t;

    logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    nib_arr_t              active_q, active_d;
    nib_arr_t              pending_q, pending_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dsel_q, dsel_d;
    logic                  fs_q, fs_d;

    logic                  tick;
    logic                  frame_bnd;
    logic                  lit;
    logic [NIB_W-1:0]      cur_nib;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      vis_seg;
    logic [NUM_DIGITS-1:0] lz_blank;

    assign tick      = (pre_cnt_q == PRE_W'(SCAN_DIV - 1));
    assign frame_bnd = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign lit       = (BRT_W'(pre_cnt_q) < brightness);
    assign cur_nib   = active_q[idx_q];

    // Digit g is a leading zero when it and every more significant nibble are zero.
    assign lz_blank[0] = 1'b0;
    for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lz
        assign lz_blank[g] = (active_q[NUM_DIGITS-1:g] == '0);
    end

    seg_decoder u_dec (
        .nibble_i   (cur_nib),
        .hex_mode_i (hex_mode),
        .seg_c      (dec_seg)
    );

    assign vis_seg = (blank_lz && lz_blank[idx_q]) ? SEG_BLANK : dec_seg;

    always_comb begin
        pre_cnt_d   = tick ? '0 : pre_cnt_q + PRE_W'(1);
        idx_d       = idx_q;
        active_d    = active_q;
        pending_d   = pending_q;
        act_dp_d    = act_dp_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;

        if (tick) begin
            idx_d = frame_bnd ? '0 : idx_q + IDX_W'(1);
        end

        // Active only changes on a frame boundary, so a frame never mixes old and new digits.
        if (load) begin
            pending_d = digits_in;
            pend_dp_d = dp_in;
            if (frame_bnd) begin
                active_d    = digits_in;
                act_dp_d    = dp_in;
                pend_flag_d = 1'b0;
            end else begin
                pend_flag_d = 1'b1;
            end
        end else if (frame_bnd && pend_flag_q) begin
            active_d    = pending_q;
            act_dp_d    = pend_dp_q;
            pend_flag_d = 1'b0;
        end

        seg_d  = (lit ? vis_seg : SEG_BLANK) ^ {SEG_W{SEG_ACTIVE_LOW}};
        dp_d   = (lit & act_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
        dsel_d = (lit ? (NUM_DIGITS'(1) << idx_q) : '0) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        fs_d   = (idx_q == '0) && (pre_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q   <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            act_dp_q    <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= {SEG_W{SEG_ACTIVE_LOW}};
            dp_q        <= SEG_ACTIVE_LOW;
            dsel_q      <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            fs_q        <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            act_dp_q    <= act_dp_d;
            pend_dp_q   <= pend_dp_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dsel_q      <= dsel_d;
            fs_q        <= fs_d;
        end
    end

    assign segments    = seg_q;
    assign dp          = dp_q;
    assign digit_sel   = dsel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: 4 digits, 4 clocks per slot; an active-high and an
// active-low instance share stimulus and are checked against a frame-arithmetic model.
module tb_seven_segment_mux;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        hex_mode;
    logic        blank_lz;
    logic [2:0]  brightness;

    logic [6:0]  segments,  segments_n;
    logic        dp,        dp_n;
    logic [3:0]  digit_sel, digit_sel_n;
    logic        frame_start, frame_start_n;

    int checks = 0;
    int errors = 0;

    seven_segment_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .brightness(brightness),
        .segments(segments), .dp(dp), .digit_sel(digit_sel), .frame_start(frame_start)
    );

    seven_segment_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .brightness(brightness),
        .segments(segments_n), .dp(dp_n), .digit_sel(digit_sel_n), .frame_start(frame_start_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model: position in the frame is derived from a cycle count since reset.
    int          cyc;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pf;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs;
    logic [3:0]  exp_dsel;

    always @(posedge clk) begin
        int         pre, d;
        bit         lit, bnd, blank;
        logic [3:0] nib;
        if (reset) begin
            cyc = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pf = 0;
            exp_seg = '0; exp_dp = 1'b0; exp_dsel = '0; exp_fs = 1'b0;
        end else begin
            pre   = cyc % 4;
            d     = (cyc / 4) % 4;
            lit   = pre < int'(brightness);
            nib   = 4'(m_act >> (4 * d));
            blank = blank_lz && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
            if (!lit || blank || (nib > 4'd9 && !hex_mode)) exp_seg = 7'b0;
            else exp_seg = seg_tab[nib];
            exp_dp   = lit && m_adp[d[1:0]];
            exp_dsel = lit ? (4'b0001 << d) : 4'b0000;
            exp_fs   = (cyc % 16) == 0;
            bnd      = (cyc % 16) == 15;
            if (load) begin
                if (bnd) begin m_act = digits_in; m_adp = dp_in; m_pf = 0; end
                else begin m_pend = digits_in; m_pdp = dp_in; m_pf = 1; end
            end else if (bnd && m_pf) begin
                m_act = m_pend; m_adp = m_pdp; m_pf = 0;
            end
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("seg",    32'(segments),           32'(exp_seg));
        chk("dp",     32'(dp),                 32'(exp_dp));
        chk("dsel",   32'(digit_sel),          32'(exp_dsel));
        chk("fs",     32'(frame_start),        32'(exp_fs));
        chk("seg_n",  32'(segments_n ^ 7'h7F), 32'(exp_seg));
        chk("dp_n",   32'(dp_n ^ 1'b1),        32'(exp_dp));
        chk("dsel_n", 32'(digit_sel_n ^ 4'hF), 32'(exp_dsel));
        chk("fs_n",   32'(frame_start_n),      32'(exp_fs));
    endtask

    // One clock: DUT and model update on posedge, outputs compared on the following negedge.
    task automatic step();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic wait_fs();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_start) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fs_timeout: no frame_start within 40 cycles at %0t", $time);
        end
    endtask

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    int         cap_lit [4];

    task automatic capture_frame();
        for (int d = 0; d < 4; d++) begin cap_seg[d] = '0; cap_dp[d] = 1'b0; cap_lit[d] = 0; end
        for (int k = 0; k < 16; k++) begin
            cap_seg[k / 4] = cap_seg[k / 4] | segments;
            cap_dp[k / 4]  = cap_dp[k / 4] | dp;
            cap_lit[k / 4] = cap_lit[k / 4] + int'(digit_sel[k / 4]);
            step();
        end
    endtask

    task automatic do_load(input logic [15:0] din, input logic [3:0] dpin);
        digits_in = din; dp_in = dpin; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    typedef struct {
        logic [15:0] din;
        logic [3:0]  dpin;
        bit          hx;
        bit          blz;
        logic [2:0]  bri;
        logic [27:0] exp_seg;  // {digit3, digit2, digit1, digit0}
        logic [3:0]  exp_dp;
        int          exp_lit;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [27:0] es;

        vecs[0] = '{16'h1234, 4'b0000, 0, 0, 3'd4, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b0000, 4};
        vecs[1] = '{16'h5678, 4'b0000, 0, 0, 3'd4, {7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111}, 4'b0000, 4};
        vecs[2] = '{16'h00AF, 4'b0000, 0, 0, 3'd4, {7'b0111111, 7'b0111111, 7'b0000000, 7'b0000000}, 4'b0000, 4};
        vecs[3] = '{16'h00AF, 4'b0000, 1, 0, 3'd4, {7'b0111111, 7'b0111111, 7'b1110111, 7'b1110001}, 4'b0000, 4};
        vecs[4] = '{16'h0010, 4'b0000, 0, 1, 3'd4, {7'b0000000, 7'b0000000, 7'b0000110, 7'b0111111}, 4'b0000, 4};
        vecs[5] = '{16'h0000, 4'b1000, 0, 1, 3'd4, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b1000, 4};
        vecs[6] = '{16'hEDCB, 4'b0101, 1, 0, 3'd1, {7'b1111001, 7'b1011110, 7'b0111001, 7'b1111100}, 4'b0101, 1};
        vecs[7] = '{16'h8888, 4'b1111, 0, 0, 3'd0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b0000, 0};
        vecs[8] = '{16'h0809, 4'b0000, 0, 1, 3'd5, {7'b0000000, 7'b1111111, 7'b0111111, 7'b1101111}, 4'b0000, 4};

        reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        hex_mode = 1'b0; blank_lz = 1'b0; brightness = 3'd4;

        // Reset state on both polarities
        step();
        step();
        chk("rst_seg",    32'(segments),    32'h00);
        chk("rst_dsel",   32'(digit_sel),   32'h0);
        chk("rst_fs",     32'(frame_start), 32'h0);
        chk("rst_seg_n",  32'(segments_n),  32'h7F);
        chk("rst_dp_n",   32'(dp_n),        32'h1);
        chk("rst_dsel_n", 32'(digit_sel_n), 32'hF);

        reset = 1'b0;
        step();
        chk("fs_after_reset", 32'(frame_start), 32'h1);

        // Table-driven display patterns: load, wait for the next frame, inspect each slot
        for (int i = 0; i < 9; i++) begin
            hex_mode = vecs[i].hx; blank_lz = vecs[i].blz; brightness = vecs[i].bri;
            do_load(vecs[i].din, vecs[i].dpin);
            wait_fs();
            capture_frame();
            es = vecs[i].exp_seg;
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("v%0d_seg%0d", i, d), 32'(cap_seg[d]), 32'(es[7 * d +: 7]));
                chk($sformatf("v%0d_dp%0d", i, d),  32'(cap_dp[d]),  32'(vecs[i].exp_dp[d]));
                chk($sformatf("v%0d_lit%0d", i, d), 32'(cap_lit[d]), 32'(vecs[i].exp_lit));
            end
        end

        // Mid-frame loads: current frame keeps old digits, the last load wins next frame
        hex_mode = 1'b0; blank_lz = 1'b0; brightness = 3'd4;
        do_load(16'h1234, 4'b0000);
        wait_fs();
        repeat (4) step();
        do_load(16'h5678, 4'b0000);
        repeat (3) step();
        do_load(16'h9999, 4'b0000);
        begin
            bit seen = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (frame_start) begin seen = 1; break; end
                if (digit_sel == 4'b0100) chk("old_frame_d2", 32'(segments), 32'(7'b1011011));
                if (digit_sel == 4'b1000) chk("old_frame_d3", 32'(segments), 32'(7'b0000110));
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL fs_timeout_midload: no frame_start within 40 cycles");
            end
        end
        capture_frame();
        for (int d = 0; d < 4; d++) chk($sformatf("last_load_seg%0d", d), 32'(cap_seg[d]), 32'(7'b1101111));

        // Reset mid-scan with a coincident load: reset wins and scanning restarts at digit 0
        repeat (8) step();
        reset = 1'b1; load = 1'b1; digits_in = 16'hFFFF;
        step();
        reset = 1'b0; load = 1'b0;
        chk("midrst_seg",    32'(segments),    32'h00);
        chk("midrst_dsel",   32'(digit_sel),   32'h0);
        chk("midrst_fs",     32'(frame_start), 32'h0);
        chk("midrst_dsel_n", 32'(digit_sel_n), 32'hF);
        step();
        chk("midrst_fs1",   32'(frame_start), 32'h1);
        chk("midrst_dsel1", 32'(digit_sel),   32'h1);
        chk("midrst_seg1",  32'(segments),    32'(7'b0111111));
        capture_frame();
        for (int d = 0; d < 4; d++) chk($sformatf("midrst_zero%0d", d), 32'(cap_seg[d]), 32'(7'b0111111));

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            load       = ($urandom_range(0, 7) == 0);
            digits_in  = 16'($urandom);
            dp_in      = 4'($urandom);
            if ($urandom_range(0, 15) == 0) hex_mode = 1'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom_range(0, 5));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
